// File: rtl/demux_pkg.sv
// Shared definitions for the pipelined 1:N stream demultiplexer.
package demux_pkg;

  // Occupancy of one node register slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Number of output channels for a given select width.
  function automatic int n_of(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/demux_node_1_2.sv
// Registered 1:2 stream node: one slot, steered by a single bit of the
// destination index that travels with the beat.
module demux_node_1_2
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int STEER  = SEL_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [SEL_W-1:0]  up_sel,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn0_valid,
  input  logic              dn0_ready,
  output logic [DATA_W-1:0] dn0_data,
  output logic              dn1_valid,
  input  logic              dn1_ready,
  output logic [DATA_W-1:0] dn1_data,
  output logic [SEL_W-1:0]  dn_sel
);

  typedef struct packed {
    slot_state_e       state;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t r_slot;

  logic w_full;
  logic w_side;
  logic w_dn_ready;
  logic w_up_xfer;
  logic w_dn_xfer;

  assign w_full     = (r_slot.state == SLOT_FULL);
  assign w_side     = r_slot.sel[STEER];
  assign w_dn_ready = w_side ? dn1_ready : dn0_ready;
  assign w_dn_xfer  = w_full && w_dn_ready;
  // A full slot can still take a beat in the same cycle it empties downstream.
  assign up_ready   = !w_full || w_dn_ready;
  assign w_up_xfer  = up_valid && up_ready;
  assign dn_sel     = r_slot.sel;

  // Slot register: fill on upstream transfer, empty on downstream-only transfer.
  // NOTE: non-blocking assignments so every node samples the pre-edge state of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole slot (not just state) is cleared; it is a single register, not a memory array.
      r_slot <= '{state: SLOT_EMPTY, sel: '0, data: '0};
    end else if (w_up_xfer) begin
      r_slot <= '{state: SLOT_FULL, sel: up_sel, data: up_data};
    end else if (w_dn_xfer) begin
      r_slot.state <= SLOT_EMPTY;
    end
  end

  // Present the beat only on the selected side; the other side reads as idle zeros.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    dn0_valid = 1'b0;
    dn1_valid = 1'b0;
    dn0_data  = '0;
    dn1_data  = '0;
    if (w_full) begin
      if (w_side) begin
        dn1_valid = 1'b1;
        dn1_data  = r_slot.data;
      end else begin
        dn0_valid = 1'b1;
        dn0_data  = r_slot.data;
      end
    end
  end

endmodule

// File: rtl/demux_1_n_pipe.sv
// Pipelined 1:N stream demultiplexer built as a binary tree of registered
// 1:2 nodes. Level L is steered by in_sel[SEL_W-1-L]; leaves drive channels.
module demux_1_n_pipe
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_W-1:0]                 in_sel,
  input  logic [DATA_W-1:0]                in_data,
  output logic [n_of(SEL_W)-1:0]           out_valid,
  input  logic [n_of(SEL_W)-1:0]           out_ready,
  output logic [n_of(SEL_W)*DATA_W-1:0]    out_data
);

  for (genvar lv = 0; lv < SEL_W; lv++) begin : g_level
    // Per-level wiring: node up_ready outputs and the links toward level lv+1.
    logic [(1<<lv)-1:0]          w_up_ready;
    logic [(2<<lv)-1:0]          w_dn_valid;
    logic [(2<<lv)*DATA_W-1:0]   w_dn_data;
    logic [(1<<lv)*SEL_W-1:0]    w_dn_sel;

    for (genvar j = 0; j < (1 << lv); j++) begin : g_node
      logic              w_up_valid;
      logic [SEL_W-1:0]  w_up_sel;
      logic [DATA_W-1:0] w_up_data;
      logic              w_dn0_ready;
      logic              w_dn1_ready;

      if (lv == 0) begin : g_root
        assign w_up_valid = in_valid;
        assign w_up_sel   = in_sel;
        assign w_up_data  = in_data;
      end else begin : g_inner
        // Sibling links share the parent's forwarded index; only one sees valid.
        assign w_up_valid = g_level[lv-1].w_dn_valid[j];
        assign w_up_sel   = g_level[lv-1].w_dn_sel[(j/2)*SEL_W +: SEL_W];
        assign w_up_data  = g_level[lv-1].w_dn_data[j*DATA_W +: DATA_W];
      end

      if (lv == SEL_W - 1) begin : g_leaf_rdy
        assign w_dn0_ready = out_ready[2*j];
        assign w_dn1_ready = out_ready[2*j+1];
      end else begin : g_mid_rdy
        assign w_dn0_ready = g_level[lv+1].w_up_ready[2*j];
        assign w_dn1_ready = g_level[lv+1].w_up_ready[2*j+1];
      end

      demux_node_1_2 #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .STEER  (SEL_W - 1 - lv)
      ) u_node (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (w_up_valid),
        .up_ready  (w_up_ready[j]),
        .up_sel    (w_up_sel),
        .up_data   (w_up_data),
        .dn0_valid (w_dn_valid[2*j]),
        .dn0_ready (w_dn0_ready),
        .dn0_data  (w_dn_data[(2*j)*DATA_W +: DATA_W]),
        .dn1_valid (w_dn_valid[2*j+1]),
        .dn1_ready (w_dn1_ready),
        .dn1_data  (w_dn_data[(2*j+1)*DATA_W +: DATA_W]),
        .dn_sel    (w_dn_sel[j*SEL_W +: SEL_W])
      );
    end

    if (lv == SEL_W - 1) begin : g_out
      // Leaf link k is channel k, so the last level maps straight onto the ports.
      assign out_valid = w_dn_valid;
      assign out_data  = w_dn_data;
      // The index has been fully consumed by the time a beat reaches a leaf.
      logic w_unused_sel;
      assign w_unused_sel = ^w_dn_sel;
    end
  end

  assign in_ready = g_level[0].w_up_ready[0];

endmodule
